// File: rtl/cpu_pkg.sv
// Shared constants for the CPU subsystem: memory geometry, loader states and
// loader error codes.
package cpu_pkg;

  localparam int ADDR_W    = 12;
  localparam int MAX_WORDS = 4096;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_RUN    = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_CHECKSUM = 2'b01;
  localparam logic [1:0] ERR_LENGTH   = 2'b10;

  localparam logic [1:0] LAST_BYTE_IDX = 2'd3;

  // States in which a frame is being received and stream bytes are wanted.
  function automatic logic is_loading(input state_t st);
    return (st == ST_LEN_LO) || (st == ST_LEN_HI) || (st == ST_DATA) || (st == ST_CHECK);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs little-endian stream bytes into 32-bit words; wordValid pulses for one
// cycle after the 4th byte, while wordData holds the completed word.
module word_assembler
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byteEn,
  input  logic [7:0]  byteIn,
  output logic        wordValid,
  output logic [31:0] wordData
);

  logic [1:0]  byteIdx;
  logic [31:0] shiftReg;

  assign wordData = shiftReg;

  // Bytes enter at the top so that after four shifts b0 sits in the low byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byteIdx   <= 2'd0;
      shiftReg  <= 32'd0;
      wordValid <= 1'b0;
    end else begin
      wordValid <= 1'b0;
      if (clear) begin
        byteIdx <= 2'd0;
      end else if (byteEn) begin
        shiftReg <= {byteIn, shiftReg[31:8]};
        byteIdx  <= byteIdx + 2'd1;
        if (byteIdx == LAST_BYTE_IDX) wordValid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed program image into instruction memory
// and releases the CPU from reset only after a clean load.
//   state  | meaning
//   IDLE   | no load yet, CPU held in reset
//   LEN_LO | expecting length low byte
//   LEN_HI | expecting length high byte; length is range-checked on acceptance
//   DATA   | receiving payload, one memory write per completed word
//   CHECK  | expecting the checksum byte
//   RUN    | load good, CPU released
//   ERROR  | load failed, err holds the cause until the next loadStart
module program_loader #(
  parameter int ADDR_W    = cpu_pkg::ADDR_W,
  parameter int MAX_WORDS = cpu_pkg::MAX_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loadStart,
  input  logic [7:0]        byteIn,
  input  logic              byteValid,
  output logic              byteReady,
  output logic              instrWrEn,
  output logic [ADDR_W-1:0] instrWrAddr,
  output logic [31:0]       instrWrData,
  output logic              cpuNRst,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  cpu_pkg::state_t state;
  logic [7:0]      lenLo;
  logic [7:0]      csum;
  logic [15:0]     wordsLeft;
  logic [15:0]     lenFull;
  logic            accept;
  logic            startLoad;
  logic            wordValid;

  assign lenFull   = {byteIn, lenLo};
  // The write cycle of each word is a one-cycle bubble so the last write can
  // finish inside DATA before the checksum byte is taken.
  assign byteReady = cpu_pkg::is_loading(state) && !(state == cpu_pkg::ST_DATA && wordValid);
  assign accept    = byteValid && byteReady;
  assign startLoad = loadStart && !cpu_pkg::is_loading(state);

  assign busy      = cpu_pkg::is_loading(state);
  assign done      = (state == cpu_pkg::ST_RUN);
  assign cpuNRst   = (state == cpu_pkg::ST_RUN);
  assign instrWrEn = wordValid;

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (startLoad),
    .byteEn    (accept && state == cpu_pkg::ST_DATA),
    .byteIn    (byteIn),
    .wordValid (wordValid),
    .wordData  (instrWrData)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= cpu_pkg::ST_IDLE;
      lenLo       <= 8'd0;
      csum        <= 8'd0;
      wordsLeft   <= 16'd0;
      instrWrAddr <= '0;
      err         <= cpu_pkg::ERR_NONE;
    end else begin
      case (state)
        cpu_pkg::ST_IDLE, cpu_pkg::ST_RUN, cpu_pkg::ST_ERROR: begin
          if (loadStart) begin
            state       <= cpu_pkg::ST_LEN_LO;
            err         <= cpu_pkg::ERR_NONE;
            csum        <= 8'd0;
            instrWrAddr <= '0;
          end
        end
        cpu_pkg::ST_LEN_LO: begin
          if (accept) begin
            lenLo <= byteIn;
            csum  <= csum ^ byteIn;
            state <= cpu_pkg::ST_LEN_HI;
          end
        end
        cpu_pkg::ST_LEN_HI: begin
          if (accept) begin
            csum      <= csum ^ byteIn;
            wordsLeft <= lenFull;
            if ({1'b0, lenFull} > MAX_LEN) begin
              state <= cpu_pkg::ST_ERROR;
              err   <= cpu_pkg::ERR_LENGTH;
            end else if (lenFull == 16'd0) begin
              state <= cpu_pkg::ST_CHECK;
            end else begin
              state <= cpu_pkg::ST_DATA;
            end
          end
        end
        cpu_pkg::ST_DATA: begin
          if (accept) csum <= csum ^ byteIn;
          if (wordValid) begin
            instrWrAddr <= instrWrAddr + ADDR_W'(1);
            wordsLeft   <= wordsLeft - 16'd1;
            if (wordsLeft == 16'd1) state <= cpu_pkg::ST_CHECK;
          end
        end
        cpu_pkg::ST_CHECK: begin
          if (accept) begin
            if (byteIn == csum) begin
              state <= cpu_pkg::ST_RUN;
            end else begin
              state <= cpu_pkg::ST_ERROR;
              err   <= cpu_pkg::ERR_CHECKSUM;
            end
          end
        end
        default: state <= cpu_pkg::ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter: ADDR_W, default 12, instruction memory address width; it matches the CPU's instructionAddress.
REQ-002 Parameter: MAX_WORDS, default 4096, largest accepted word count.
REQ-003 Port: clk  input  1  single clock; all logic is on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: loadStart  input  1  one-cycle request to begin a new load.
REQ-006 Port: byteIn  input  8  incoming stream byte.
REQ-007 Port: byteValid  input  1  byteIn holds valid data.
REQ-008 Port: byteReady  output  1  loader accepts byteIn this cycle.
REQ-009 Port: instrWrEn  output  1  instruction memory write strobe.
REQ-010 Port: instrWrAddr  output  ADDR_W  instruction memory write address.
REQ-011 Port: instrWrData  output  32  instruction memory write word.
REQ-012 Port: cpuNRst  output  1  active-low CPU reset; low holds the CPU in reset.
REQ-013 Port: busy  output  1  a load is in progress.
REQ-014 Port: done  output  1  the last load completed successfully.
REQ-015 Port: err  output  2  00 none, 01 checksum mismatch, 10 bad length.

Function
REQ-016 A byte SHALL transfer only on a cycle where byteValid and byteReady are both high; byteReady SHALL be high only in LEN_LO, LEN_HI, DATA and CHECK.
REQ-017 The frame SHALL be: length low byte, length high byte, then length x 4 data bytes with each word little-endian, then one checksum byte.
REQ-018 States SHALL be IDLE, LEN_LO, LEN_HI, DATA, CHECK, RUN and ERROR.
REQ-019 IDLE, RUN or ERROR with loadStart SHALL go to LEN_LO; the same cycle SHALL clear done and err, drive cpuNRst low and set busy.
REQ-020 loadStart SHALL be ignored in LEN_LO, LEN_HI, DATA and CHECK.
REQ-021 After LEN_HI is accepted, a 16-bit length greater than MAX_WORDS SHALL go to ERROR with err=10; a length of 0 SHALL go to CHECK; any other length SHALL go to DATA.
REQ-022 On acceptance of the 4th byte of a word, the next cycle SHALL pulse instrWrEn for exactly 1 cycle, with instrWrData = {b3,b2,b1,b0} and instrWrAddr = word index, starting at 0.
REQ-023 The word index SHALL increment after each write; DATA SHALL exit to CHECK after the write of word length-1.
REQ-024 The checksum SHALL be the XOR of every frame byte before the checksum byte, including both length bytes.
REQ-025 In CHECK, a received checksum equal to the running XOR SHALL go to RUN; otherwise it SHALL go to ERROR with err=01.
REQ-026 In RUN: cpuNRst=1, done=1, busy=0; cpuNRst SHALL rise the cycle after checksum acceptance.
REQ-027 In ERROR: cpuNRst=0, busy=0, done=0; err SHALL be held until the next loadStart.
REQ-028 instrWrEn SHALL never assert outside DATA, nor in the cycle following it.

Reset
REQ-029 rst SHALL immediately force state=IDLE and set byteReady=0, instrWrEn=0, instrWrAddr=0, instrWrData=0, cpuNRst=0, busy=0, done=0, err=00, word index=0, byte index=0 and checksum=0.
REQ-030 rst during a load SHALL abandon the load, and no partial word SHALL be written.

Structure
REQ-031 The state encoding, error codes, ADDR_W and MAX_WORDS SHALL live in the shared cpu_pkg package.
REQ-032 Byte-to-word assembly (2-bit byte index, 32-bit shift register, word-complete pulse) SHALL be the sub-module word_assembler.

Verification
REQ-033 Scenario, good load: loadStart, then bytes 01 00 78 56 34 12 09 -> one instrWrEn with addr 0 and data 0x12345678; cpuNRst=1, done=1, err=00.
REQ-034 Scenario, checksum error: same frame with checksum 0A -> one write occurs, then ERROR with err=01, cpuNRst stays 0, done=0.
REQ-035 Scenario, bad length: bytes 01 10 (length 0x1001) -> ERROR with err=10 right after the 2nd byte, byteReady=0, no writes.
REQ-036 Scenario, zero length: bytes 00 00 00 -> no instrWrEn, RUN, done=1.
REQ-037 Scenario, mid-load reset: rst asserted after 3 data bytes -> all outputs at reset values at once, no write; a fresh load then succeeds with a write at addr 0.
REQ-038 Scenario, back-pressure and gaps: byteValid high in IDLE -> byteReady=0 and nothing consumed; random byteValid gaps during the good load -> same result as REQ-033.
